// File: rtl/ram8_pkg.sv
// ============================================================================
//  Module      : ram8_pkg
//  Description : Shared constants and types for the ram8 register file.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ram8_pkg;

    localparam int RAM8_WORDS  = 8;
    localparam int RAM8_ADDR_W = 3;

    typedef logic [RAM8_ADDR_W-1:0] ram8_addr_t;

endpackage : ram8_pkg

`default_nettype wire

// File: rtl/dmux8way.sv
// ============================================================================
//  Module      : dmux8way
//  Description : Generic 1-to-8 demultiplexer built as a two-level dmux tree.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dmux8way
    import ram8_pkg::*;
(
    input  logic             in,
    input  ram8_addr_t       sel,
    output logic [RAM8_WORDS-1:0] out
);

    logic [1:0] w_half;
    logic [3:0] w_quarter;

    // Pure AND gating: an unknown select can only yield 0 or X, never a stray 1.
    assign w_half[0] = in & ~sel[2];
    assign w_half[1] = in &  sel[2];

    assign w_quarter[0] = w_half[0] & ~sel[1];
    assign w_quarter[1] = w_half[0] &  sel[1];
    assign w_quarter[2] = w_half[1] & ~sel[1];
    assign w_quarter[3] = w_half[1] &  sel[1];

    for (genvar k = 0; k < 4; k++) begin : g_leaf
        assign out[2*k]   = w_quarter[k] & ~sel[0];
        assign out[2*k+1] = w_quarter[k] &  sel[0];
    end

endmodule : dmux8way

`default_nettype wire

// File: rtl/ram8.sv
// ============================================================================
//  Module      : ram8
//  Description : Eight-word register file, async clear, combinational read.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ram8
    import ram8_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  ram8_addr_t       address,
    output logic [WIDTH-1:0] out
);

    if (DEPTH_LOG2 != RAM8_ADDR_W) begin : g_bad_depth
        $error("ram8: DEPTH_LOG2 must be 3");
    end

    logic [RAM8_WORDS-1:0] w_sel;
    logic [WIDTH-1:0]      r_word [RAM8_WORDS];

    dmux8way u_load_dmux (
        .in  (load),
        .sel (address),
        .out (w_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM8_WORDS; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RAM8_WORDS; i++) begin
                if (w_sel[i]) begin
                    r_word[i] <= in;
                end
            end
        end
    end

    // No bypass: a same-address write shows up only after the edge.
    assign out = r_word[address];

endmodule : ram8

`default_nettype wire

// File: tb/tb_ram8.sv
// ============================================================================
//  Module      : tb_ram8
//  Description : Self-checking bench for ram8 and its dmux8way load decoder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ram8;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    logic        dm_in;
    logic [2:0]  dm_sel;
    logic [7:0]  dm_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] model [8];

    typedef struct {
        logic        ld;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_pre;
        logic [15:0] exp_post;
    } vec_t;

    vec_t tbl[$];

    ram8 #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    dmux8way u_dmux (
        .in  (dm_in),
        .sel (dm_sel),
        .out (dm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_zero(input string name);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            check16(name, out, 16'h0000);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; in = '0; address = '0;
        dm_in = 1'b0; dm_sel = '0;

        // dmux8way exhaustive
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 2; b++) begin
                logic [7:0] exp_v;
                dm_sel = 3'(s);
                dm_in  = 1'(b);
                exp_v  = '0;
                exp_v[s] = 1'(b);
                #1;
                check8("dmux8way", dm_out, exp_v);
            end
        end

        // Reset clears arbitrary prior contents
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            load = 1'b1; address = 3'(a); in = 16'($urandom) | 16'h0001;
            tick();
        end
        load = 1'b1; in = 16'hDEAD;
        #2;
        reset = 1'b1;
        sweep_zero("reset_during");
        tick();
        sweep_zero("reset_edge_load1");
        load = 1'b0;
        reset = 1'b0;
        tick();
        sweep_zero("reset_after");

        // Table: single write, fill/reverse readback, hold, read-during-write
        tbl.push_back('{1'b1, 3'd3, 16'hA5A5, 16'h0000, 16'hA5A5});
        for (int a = 0; a < 8; a++)
            tbl.push_back('{1'b0, 3'(a), 16'hFFFF, (a == 3) ? 16'hA5A5 : 16'h0000,
                            (a == 3) ? 16'hA5A5 : 16'h0000});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, 3'(i), 16'h1000 + 16'(i), (i == 3) ? 16'hA5A5 : 16'h0000,
                            16'h1000 + 16'(i)});
        for (int i = 7; i >= 0; i--)
            tbl.push_back('{1'b0, 3'(i), 16'h0BAD, 16'h1000 + 16'(i), 16'h1000 + 16'(i)});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1'b0, 3'(i % 8), 16'h0BAD, 16'h1000 + 16'(i % 8), 16'h1000 + 16'(i % 8)});
        tbl.push_back('{1'b1, 3'd5, 16'h0001, 16'h1005, 16'h0001});
        tbl.push_back('{1'b1, 3'd5, 16'hFFFF, 16'h0001, 16'hFFFF});
        for (int a = 0; a < 8; a++)
            tbl.push_back('{1'b0, 3'(a), 16'h0000, (a == 5) ? 16'hFFFF : 16'h1000 + 16'(a),
                            (a == 5) ? 16'hFFFF : 16'h1000 + 16'(a)});

        foreach (tbl[k]) begin
            load = tbl[k].ld; address = tbl[k].addr; in = tbl[k].din;
            #1;
            check16($sformatf("tbl%0d_pre", k), out, tbl[k].exp_pre);
            tick();
            check16($sformatf("tbl%0d_post", k), out, tbl[k].exp_post);
        end

        // Reset mid-cycle with a pending write to word 7
        load = 1'b1; in = 16'hBEEF; address = 3'd7;
        #1;
        check16("w7_before_reset", out, 16'h1007);
        reset = 1'b1;
        #1;
        check16("w7_async_clear", out, 16'h0000);
        tick();
        check16("w7_edge_in_reset", out, 16'h0000);
        reset = 1'b0; in = 16'h1234; address = 3'd2;
        tick();
        check16("first_edge_write", out, 16'h1234);
        load = 1'b0; address = 3'd7;
        #1;
        check16("w7_still_zero", out, 16'h0000);

        for (int a = 0; a < 8; a++) model[a] = '0;
        model[2] = 16'h1234;

        // Randomized traffic against an array model
        for (int c = 0; c < 400; c++) begin
            load = 1'($urandom_range(0, 1));
            address = 3'($urandom_range(0, 7));
            in = 16'($urandom);
            #1;
            check16("rand_pre", out, model[address]);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                check16("rand_reset", out, 16'h0000);
                for (int a = 0; a < 8; a++) model[a] = '0;
                tick();
                reset = 1'b0;
            end else begin
                @(posedge clk);
                if (load) model[address] = in;
                #1;
                check16("rand_post", out, model[address]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram8

`default_nettype wire

// File: doc/ram8.md
Name: ram8

Overview:
- Eight-word register file: the bottom level of the memory hierarchy, later tiled into ram64/ram512.
- Write path fans one `load` strobe out to exactly one of eight word registers, selected by `address`. This is the 1-to-8 distribution that complements the existing 8-to-1 reduction gates.
- Read path selects the addressed word combinationally.
- Sits under the CPU data memory and is also used standalone as the register bank in unit benches.

Parameters:
- WIDTH, 16, bits per word.
- DEPTH_LOG2, 3, address bits; fixed at 3 (8 words). Any other value is a compile-time error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all eight words immediately.
- in  input  WIDTH  write data.
- load  input  1  write strobe; sampled on rising clk edge.
- address  input  3  word select for both read and write.
- out  output  WIDTH  contents of word[address].

Behaviour:
- Storage: word[0..7], each WIDTH bits.
- Reset values:
  - While reset=1, all word[i]=0 regardless of clk or load.
  - Clearing takes effect asynchronously, within the same delta cycle as reset rising.
  - out=0 whenever reset is asserted.
- Deassertion of reset: the first rising clk edge with reset=0 is a normal edge. If load=1 on that edge, the write takes effect.
- Write:
  - On rising clk edge with reset=0 and load=1: word[address] <= in.
  - Every other word holds its value.
  - Write latency is 1 cycle.
- Load fan-out:
  - sel[7:0] = one-hot decode of address, gated by load.
  - sel[i]=load when address==i, else 0.
  - At most one sel bit is high at any time. With load=0, sel=8'b0.
- Hold: with load=0, all words hold indefinitely.
- Read:
  - out = word[address], purely combinational, with 0-cycle latency from an address change.
- Read-during-write, same address:
  - Before the edge, out shows the old value.
  - After the edge, out shows the new value.
  - There is no write-through bypass before the edge.
- Address change coincident with the edge: the address sampled at the edge selects the write target.
- X handling: an X on address with load=1 must not corrupt non-selected words in simulation. The decode must produce all-zero or X only on sel bits, never a spurious 1.
- Reset asserted mid-sequence: pending writes are discarded; reset dominates load.
- Internal state: no other state beyond the eight words. Do not add a registered read.
- Width rules: no truncation or extension; in, word and out are all exactly WIDTH bits.

Decomposition:
- Shared include (alongside the elementary gate include):
  - `RAM8_WORDS` = 8.
  - Address-width constant = 3.
- Sub-module dmux8way(out0..out7 or out[7:0], in, sel[2:0]):
  - Generic 1-to-8 demultiplexer.
  - Built from two-level dmux structure over the elementary gates.
  - Reusable later by ram64/ram512 for bank select.
- Word register:
  - One WIDTH-bit register with load enable and async reset.
  - Instantiated 8 times, or written inline with a generate loop.
- Read mux: mux8way over WIDTH bits. May be a second helper module (mux8way16) if the team wants symmetry.

Test Plan:
1. Assert reset with arbitrary prior contents, then sweep address 0..7 -> out=0 for every address, both during and after reset with load=0.
2. Write 16'hA5A5 to address 3 (load=1, one edge), then read addresses 0..7 -> out=16'hA5A5 at address 3 only, 0 elsewhere.
3. Write word[i]=16'h1000+i for i=0..7, then read back in reverse order -> each out matches. With load=0 for 10 cycles, all values are retained.
4. Same-address read-during-write: word[5]=16'h0001, then apply in=16'hFFFF, load=1, address=5 -> out=16'h0001 before the edge, 16'hFFFF after. Other words are unchanged.
5. Reset mid-operation: reset asserted asynchronously between edges while load=1, in=16'hBEEF, address=7 -> word[7]=0 immediately. On the following edge with reset still high, word[7] stays 0.
6. dmux8way exhaustive: all 8 sel values × in∈{0,1} -> exactly one output equals in and the other seven are 0.
